link_slave_fsm: RTL
===================

// Module: link_slave_fsm
// PURPOSE
//  Responder end of the 4-phase req/ack byte link. Samples data while req is high.
//  Raises ack and holds it until req falls. Stores each frame of NUM_BYTES bytes.
//  Reports frame completion. Sits opposite the link initiator on the same clk domain.
// PARAMETERS
//  NUM_BYTES  4  bytes per frame; must be >=2 and a power of 2 (index wraps naturally)
//  ACK_HOLD   2  minimum cycles ack stays high before req-low is honoured; >=1
// PORTS
//  clk         in   1  rising-edge clock
//  rst         in   1  synchronous, active-high reset
//  req         in   1  initiator request; data_in valid while high
//  data_in     in   8  byte from initiator
//  ack         out  1  registered acknowledge to initiator
//  rd_addr     in   $clog2(NUM_BYTES)  read index into capture buffer
//  rd_data     out  8  combinational mem[rd_addr]
//  last_byte   out  8  most recently captured byte
//  byte_cnt    out  $clog2(NUM_BYTES)+1  completed handshakes in current frame
//  frame_cnt   out  8  completed frames, wraps 255->0
//  done        out  1  one-cycle pulse on frame completion
//  proto_err   out  1  sticky: req fell before ACK_HOLD elapsed
// BEHAVIOUR
//  Reset: ack=0, done=0, proto_err=0, last_byte=0, byte_cnt=0, frame_cnt=0.
//   Also wr_idx=0, hold_cnt=0, all mem[] cleared to 0, state=IDLE.
//   Reset mid-handshake aborts it; ack drops on the next cycle.
//  All outputs are registered except rd_data. Only one process drives each reg.
//  States: IDLE, HOLD, WAIT_LOW, DONE.
//  IDLE: ack=0.
//   If req=1 at edge N: mem[wr_idx]<=data_in and last_byte<=data_in.
//   Also hold_cnt<=0 and ack<=1, so ack is visible in cycle N+1. Go to HOLD.
//  HOLD: ack=1; hold_cnt++ each cycle. When hold_cnt==ACK_HOLD-1, go to WAIT_LOW.
//   If req=0 is sampled in HOLD: proto_err<=1 (sticky). HOLD still runs to term.
//  WAIT_LOW: ack=1 until req=0 is sampled. Then ack<=0, wr_idx++, byte_cnt++.
//   If byte_cnt was NUM_BYTES-1, go to DONE; else go to IDLE.
//  DONE: done=1 for exactly this cycle. byte_cnt<=0, wr_idx<=0, frame_cnt++.
//   Go to IDLE. req is ignored in DONE; a req held high is taken in the next IDLE.
//  Minimum handshake: 1 (IDLE) + ACK_HOLD (HOLD) + 1 (WAIT_LOW, req already low).
//  Data is sampled only on the IDLE->HOLD edge. data_in changes afterward are ignored.
//  req must return low before a new byte is accepted. A req stuck high never re-captures.
//  rd_data reflects a write on the cycle after the write edge.
//   Same-cycle read of the written address returns the old value.
//  frame_cnt wraps modulo 256 with no flag. byte_cnt never exceeds NUM_BYTES-1 outside DONE.
// TESTING
//  1 rst=1 for 2 cycles mid-transfer -> ack=0, byte_cnt=0, frame_cnt=0, mem all 0, state IDLE.
//  2 initiator sends A0,A1,A2,A3 with req dropped 1 cycle after ack -> each ack stays high for
//    >=ACK_HOLD+1 cycles; done pulses once; mem=A0..A3; frame_cnt=1; byte_cnt=0; proto_err=0.
//  3 req raised at edge N with ACK_HOLD=2 -> ack high in cycles N+1..N+3 minimum; data_in
//    changed to FF at N+1 -> last_byte stays at the value sampled at N.
//  4 req pulsed high 1 cycle only -> byte captured, proto_err=1, and it stays 1 through
//    3 more good bytes and done; cleared only by rst.
//  5 req held high across 6 cycles after done -> exactly one new capture (mem[0]), no second
//    byte until req goes low.
//  6 run 257 frames -> frame_cnt reads 1; done pulsed 257 times, each 1 cycle wide.

Source files
------------

// File: rtl/link_slave_fsm.sv
// link_slave_fsm
//   Responder end of a 4-phase req/ack byte link. It captures one byte per
//   handshake into a NUM_BYTES-deep buffer, holds ack for at least ACK_HOLD
//   cycles, and flags frame completion once NUM_BYTES handshakes are done.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        initiator request; data_in is valid while high
//   data_in    byte from the initiator
//   ack        registered acknowledge to the initiator
//   rd_addr    read index into the capture buffer
//   rd_data    combinational read of the buffer at rd_addr
//   last_byte  most recently captured byte
//   byte_cnt   completed handshakes in the current frame
//   frame_cnt  completed frames, wraps modulo 256
//   done       one-cycle pulse on frame completion
//   proto_err  sticky: req fell while ack was still in its hold window
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | ack low, waiting for req; the byte is captured on leaving
// S_HOLD   | ack high, minimum hold window running (hold_cnt counts up)
// S_WAIT   | ack high, waiting for req to be sampled low
// S_DONE   | frame complete, done high for this cycle, counters cleared

module link_slave_fsm #(
  parameter int NUM_BYTES = 4,
  parameter int ACK_HOLD  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic [7:0]                   data_in,
  output logic                         ack,
  input  logic [$clog2(NUM_BYTES)-1:0] rd_addr,
  output logic [7:0]                   rd_data,
  output logic [7:0]                   last_byte,
  output logic [$clog2(NUM_BYTES):0]   byte_cnt,
  output logic [7:0]                   frame_cnt,
  output logic                         done,
  output logic                         proto_err
);

  localparam int AW = $clog2(NUM_BYTES);
  // hold_cnt reaches ACK_HOLD on the exit edge, so size it to hold that value
  localparam int HW = $clog2(ACK_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_TC = HW'(ACK_HOLD - 1);
  localparam logic [AW:0]   LAST_CNT = (AW + 1)'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_ack, w_ack_nxt;
  logic          r_done, w_done_nxt;
  logic          r_perr, w_perr_nxt;
  logic [7:0]    r_last, w_last_nxt;
  logic [AW:0]   r_byte_cnt, w_byte_cnt_nxt;
  logic [7:0]    r_frame_cnt, w_frame_cnt_nxt;
  logic [AW-1:0] r_wr_idx, w_wr_idx_nxt;
  logic [HW-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic          w_wr_en;
  logic [7:0]    r_mem [NUM_BYTES];

  always_comb begin
    w_state_nxt     = r_state;
    w_ack_nxt       = r_ack;
    w_done_nxt      = 1'b0;
    w_perr_nxt      = r_perr;
    w_last_nxt      = r_last;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_frame_cnt_nxt = r_frame_cnt;
    w_wr_idx_nxt    = r_wr_idx;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_wr_en         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ack_nxt = 1'b0;
        if (req) begin
          w_wr_en        = 1'b1;
          w_last_nxt     = data_in;
          w_hold_cnt_nxt = '0;
          w_ack_nxt      = 1'b1;
          w_state_nxt    = S_HOLD;
        end
      end
      S_HOLD: begin
        w_hold_cnt_nxt = r_hold_cnt + HW'(1);
        // an early req drop is only flagged; the hold window still completes
        if (!req) w_perr_nxt = 1'b1;
        if (r_hold_cnt == HOLD_TC) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!req) begin
          w_ack_nxt      = 1'b0;
          w_wr_idx_nxt   = r_wr_idx + AW'(1);
          w_byte_cnt_nxt = r_byte_cnt + (AW + 1)'(1);
          if (r_byte_cnt == LAST_CNT) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DONE: begin
        w_byte_cnt_nxt  = '0;
        w_wr_idx_nxt    = '0;
        w_frame_cnt_nxt = r_frame_cnt + 8'd1;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ack       <= 1'b0;
      r_done      <= 1'b0;
      r_perr      <= 1'b0;
      r_last      <= '0;
      r_byte_cnt  <= '0;
      r_frame_cnt <= '0;
      r_wr_idx    <= '0;
      r_hold_cnt  <= '0;
      for (int i = 0; i < NUM_BYTES; i++) r_mem[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack       <= w_ack_nxt;
      r_done      <= w_done_nxt;
      r_perr      <= w_perr_nxt;
      r_last      <= w_last_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_wr_idx    <= w_wr_idx_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      if (w_wr_en) r_mem[r_wr_idx] <= data_in;
    end
  end

  assign ack       = r_ack;
  assign done      = r_done;
  assign proto_err = r_perr;
  assign last_byte = r_last;
  assign byte_cnt  = r_byte_cnt;
  assign frame_cnt = r_frame_cnt;
  assign rd_data   = r_mem[rd_addr];

endmodule
